fp16_result_deserializer: RTL

- Downstream stage of the serial FP16 divider: consumes the serial result stream (bit + tready qualifier) and reassembles 16-bit half-precision words {sign, exponent[4:0], fraction[9:0]}.
- Classifies each word (zero/subnormal/inf/NaN) and buffers it in a small FIFO.
- Presents results on a parallel valid/ready interface to the consumer (register file or host readout).

---
 rtl/fp16_result_deserializer_if.sv | 30 +++
 rtl/fp16_result_deserializer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fp16_result_deserializer_if.sv
// ---------------------------------------------------------------------------
// fp16_result_deserializer_if
// Groups the serial input stream and the parallel result handshake of the
// FP16 result deserializer.
//   s_bit     serial result bit, MSB (sign) first
//   s_tready  qualifier: s_bit is valid in every cycle this is high
//   m_tdata   head-of-FIFO word {sign, exp[4:0], frac[9:0]}
//   m_flags   {nan, inf, zero, sub} classification of m_tdata
//   m_tvalid  FIFO non-empty
//   m_tready  consumer accepts the head word
// The slave modport is the deserializer's view; master is the environment's.
// ---------------------------------------------------------------------------
interface fp16_result_deserializer_if;
  logic        s_bit;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic [3:0]  m_flags;
  logic        m_tvalid;
  logic        m_tready;

  modport slave (
    input  s_bit, s_tready, m_tready,
    output m_tdata, m_flags, m_tvalid
  );

  modport master (
    output s_bit, s_tready, m_tready,
    input  m_tdata, m_flags, m_tvalid
  );
endinterface

// File: rtl/fp16_result_deserializer.sv
// ---------------------------------------------------------------------------
// fp16_result_deserializer
// Reassembles MSB-first serial FP16 results into 16-bit words, buffers them
// in a DEPTH-entry FIFO and presents the head word with its classification.
// Ports:
//   clk        system clock, rising edge
//   res        synchronous active-high reset
//   bus        serial input + parallel valid/ready output (slave modport)
//   level      current FIFO occupancy (0..DEPTH)
//   overflow   sticky: a completed word was dropped on a full FIFO
//   frame_err  sticky: a partial frame was aborted by a gap timeout
//   drop_cnt   number of dropped words, saturating at all-ones
// ---------------------------------------------------------------------------
module fp16_result_deserializer #(
  parameter int DEPTH   = 4,
  parameter int GAP_MAX = 8,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     res,
  fp16_result_deserializer_if.slave bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     frame_err,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(GAP_MAX + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // {nan, inf, zero, sub} from exponent/fraction; sign does not matter.
  function automatic logic [3:0] classify(input logic [14:0] ef);
    logic [4:0] e;
    logic [9:0] f;
    e = ef[14:10];
    f = ef[9:0];
    return {(e == 5'h1F) && (f != 10'h000),
            (e == 5'h1F) && (f == 10'h000),
            (e == 5'h00) && (f == 10'h000),
            (e == 5'h00) && (f != 10'h000)};
  endfunction

  logic [0:0]       state_q, state_d;
  // Only the 15 older bits are held; the 16th bit is taken straight from
  // s_bit in the completing cycle.
  logic [14:0]      shreg_q, shreg_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [15:0]      mem_q [DEPTH];
  logic             overflow_q, overflow_d;
  logic             frame_err_q, frame_err_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic        push_s, abort_s, pop_s, wr_en_s, drop_s, empty_s, full_s;
  logic [15:0] word_s, head_s;

  assign word_s  = {shreg_q, bus.s_bit};
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_s   = !empty_s && bus.m_tready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en_s = push_s && (!full_s || pop_s);
  assign drop_s  = push_s && full_s && !pop_s;

  // Serial frame assembly and gap-timeout FSM.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    push_s  = 1'b0;
    abort_s = 1'b0;
    if (bus.s_tready) begin
      shreg_d = {shreg_q[13:0], bus.s_bit};
    end else begin
      shreg_d = shreg_q;
    end
    case (state_q)
      ST_IDLE: begin
        gap_d = '0;
        if (bus.s_tready) begin
          cnt_d   = 4'd1;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = 4'd0;
        end
      end
      ST_SHIFT: begin
        if (bus.s_tready) begin
          gap_d = '0;
          if (cnt_q == 4'd15) begin
            push_s  = 1'b1;
            cnt_d   = 4'd0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else if (gap_q == GW'(GAP_MAX - 1)) begin
          abort_s = 1'b1;
          gap_d   = '0;
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        gap_d   = '0;
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO pointer and sticky status next-state.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q | drop_s;
    frame_err_d = frame_err_q | abort_s;
    drop_cnt_d  = drop_cnt_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (drop_s && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cnt_q       <= 4'd0;
      gap_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // FIFO storage; contents are only visible through a non-empty head.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= word_s;
    end
  end

  assign head_s       = mem_q[rd_ptr_q[AW-1:0]];
  // Gate stale storage so an empty FIFO shows zero data and flags.
  assign bus.m_tdata  = empty_s ? 16'h0000 : head_s;
  assign bus.m_flags  = empty_s ? 4'b0000 : classify(head_s[14:0]);
  assign bus.m_tvalid = !empty_s;
  assign level        = wr_ptr_q - rd_ptr_q;
  assign overflow     = overflow_q;
  assign frame_err    = frame_err_q;
  assign drop_cnt     = drop_cnt_q;

endmodule
